// File: rtl/barrier_spawn_scheduler.sv
// Barrier spawn scheduler: paces barrier spawns by frame count, strobes the
// parameter generator, captures its outputs into a free slot and ages each slot out.
module barrier_spawn_scheduler #(
  parameter int NUM_SLOTS      = 4,
  parameter int SPAWN_INTERVAL = 60,
  parameter int LIFETIME       = 300
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     Frame_Tick,
  input  logic                     Game_Enable,
  input  logic [9:0]               Gen_X,
  input  logic [9:0]               Gen_Y,
  input  logic [9:0]               Gen_Height,
  input  logic [9:0]               Gen_Length,
  output logic                     Gen_Load,
  output logic [NUM_SLOTS*10-1:0]  Barrier_X,
  output logic [NUM_SLOTS*10-1:0]  Barrier_Y,
  output logic [NUM_SLOTS*10-1:0]  Barrier_Height,
  output logic [NUM_SLOTS*10-1:0]  Barrier_Length,
  output logic [NUM_SLOTS-1:0]     Slot_Active,
  output logic                     Spawn_Done,
  output logic [7:0]               Spawn_Count
);

  localparam int         IDXW         = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [7:0] SPAWN_RELOAD = 8'(SPAWN_INTERVAL);
  localparam logic [8:0] LIFE_RELOAD  = 9'(LIFETIME);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, CAPTURE} state_t;

  state_t          r_State;
  logic [7:0]      r_SpawnCnt;
  logic [IDXW-1:0] r_Target;
  logic [8:0]      r_Life [NUM_SLOTS];

  logic [IDXW-1:0] w_FreeIdx;
  logic            w_AnyFree;
  logic            w_Capture;

  // Lowest-index free slot; only meaningful when w_AnyFree is set.
  always_comb begin
    w_FreeIdx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!Slot_Active[i]) w_FreeIdx = IDXW'(i);
    end
  end

  assign w_AnyFree = ~&Slot_Active;
  assign w_Capture = (r_State == CAPTURE) && Game_Enable;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_State     <= IDLE;
      r_SpawnCnt  <= SPAWN_RELOAD;
      r_Target    <= '0;
      Gen_Load    <= 1'b0;
      Spawn_Done  <= 1'b0;
      Spawn_Count <= 8'd0;
    end else if (!Game_Enable) begin
      r_State    <= IDLE;
      r_SpawnCnt <= SPAWN_RELOAD;
      Gen_Load   <= 1'b0;
      Spawn_Done <= 1'b0;
    end else begin
      Gen_Load   <= 1'b0;
      Spawn_Done <= 1'b0;
      if (Frame_Tick && (r_SpawnCnt != 8'd0)) r_SpawnCnt <= r_SpawnCnt - 8'd1;
      case (r_State)
        IDLE: begin
          if ((r_SpawnCnt == 8'd0) && w_AnyFree) begin
            r_State    <= LOAD;
            r_Target   <= w_FreeIdx;
            r_SpawnCnt <= SPAWN_RELOAD;
            Gen_Load   <= 1'b1;
          end
        end
        LOAD: r_State <= WAIT;
        WAIT: begin
          r_State    <= CAPTURE;
          Spawn_Done <= 1'b1;
        end
        CAPTURE: begin
          r_State     <= IDLE;
          Spawn_Count <= Spawn_Count + 8'd1;
        end
        default: r_State <= IDLE;
      endcase
    end
  end

  // A capture on a slot takes precedence over that slot's own frame aging.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Slot_Active    <= '0;
      Barrier_X      <= '0;
      Barrier_Y      <= '0;
      Barrier_Height <= '0;
      Barrier_Length <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) r_Life[i] <= 9'd0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (!Game_Enable) begin
          Slot_Active[i] <= 1'b0;
          r_Life[i]      <= 9'd0;
        end else if (w_Capture && (r_Target == IDXW'(i))) begin
          Barrier_X[i*10 +: 10]      <= Gen_X;
          Barrier_Y[i*10 +: 10]      <= Gen_Y;
          Barrier_Height[i*10 +: 10] <= Gen_Height;
          Barrier_Length[i*10 +: 10] <= Gen_Length;
          Slot_Active[i]             <= 1'b1;
          r_Life[i]                  <= LIFE_RELOAD;
        end else if (Frame_Tick && Slot_Active[i]) begin
          if (r_Life[i] == 9'd1) begin
            Slot_Active[i] <= 1'b0;
            r_Life[i]      <= 9'd0;
          end else begin
            r_Life[i] <= r_Life[i] - 9'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_barrier_spawn_scheduler.sv
// Randomized self-checking bench for barrier_spawn_scheduler against a
// transaction-level model of spawning, slot lifetimes and enable/reset overrides.
module tb_barrier_spawn_scheduler;

  localparam int NS = 4;
  localparam int SI = 3;
  localparam int LT = 20;

  logic            Clk = 1'b0;
  logic            Reset;
  logic            Frame_Tick;
  logic            Game_Enable;
  logic [9:0]      Gen_X, Gen_Y, Gen_Height, Gen_Length;
  logic            Gen_Load;
  logic [NS*10-1:0] Barrier_X, Barrier_Y, Barrier_Height, Barrier_Length;
  logic [NS-1:0]   Slot_Active;
  logic            Spawn_Done;
  logic [7:0]      Spawn_Count;

  int errors = 0;
  int checks = 0;

  // Model: phase 0=idle, 1=generator strobed, 2=settling, 3=capturing.
  bit         mActive [NS];
  int         mLife   [NS];
  logic [9:0] mX [NS];
  logic [9:0] mY [NS];
  logic [9:0] mH [NS];
  logic [9:0] mL [NS];
  int         mSpawnCnt, mPhase, mTarget, mCount;

  barrier_spawn_scheduler #(
    .NUM_SLOTS(NS), .SPAWN_INTERVAL(SI), .LIFETIME(LT)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Frame_Tick(Frame_Tick), .Game_Enable(Game_Enable),
    .Gen_X(Gen_X), .Gen_Y(Gen_Y), .Gen_Height(Gen_Height), .Gen_Length(Gen_Length),
    .Gen_Load(Gen_Load),
    .Barrier_X(Barrier_X), .Barrier_Y(Barrier_Y),
    .Barrier_Height(Barrier_Height), .Barrier_Length(Barrier_Length),
    .Slot_Active(Slot_Active), .Spawn_Done(Spawn_Done), .Spawn_Count(Spawn_Count)
  );

  always #5 Clk = ~Clk;

  task automatic modelReset();
    for (int i = 0; i < NS; i++) begin
      mActive[i] = 1'b0; mLife[i] = 0;
      mX[i] = '0; mY[i] = '0; mH[i] = '0; mL[i] = '0;
    end
    mSpawnCnt = SI; mPhase = 0; mTarget = 0; mCount = 0;
  endtask

  task automatic modelStep(input bit tick, input bit en);
    int  freeSlot;
    int  oldCnt;
    bit  capture;
    if (Reset) begin
      modelReset();
      return;
    end
    if (!en) begin
      for (int i = 0; i < NS; i++) begin mActive[i] = 1'b0; mLife[i] = 0; end
      mPhase = 0; mSpawnCnt = SI;
      return;
    end
    freeSlot = -1;
    for (int i = NS - 1; i >= 0; i--) if (!mActive[i]) freeSlot = i;
    oldCnt  = mSpawnCnt;
    capture = (mPhase == 3);
    for (int i = 0; i < NS; i++) begin
      if (capture && i == mTarget) begin
        mX[i] = Gen_X; mY[i] = Gen_Y; mH[i] = Gen_Height; mL[i] = Gen_Length;
        mActive[i] = 1'b1; mLife[i] = LT;
      end else if (tick && mActive[i]) begin
        mLife[i]--;
        if (mLife[i] == 0) mActive[i] = 1'b0;
      end
    end
    if (tick && mSpawnCnt > 0) mSpawnCnt--;
    if (mPhase == 0) begin
      if (oldCnt == 0 && freeSlot >= 0) begin
        mPhase = 1; mTarget = freeSlot; mSpawnCnt = SI;
      end
    end else if (mPhase == 3) begin
      mPhase = 0; mCount = (mCount + 1) % 256;
    end else begin
      mPhase++;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    logic [NS*10-1:0] eX, eY, eH, eL;
    logic [NS-1:0]    eAct;
    for (int i = 0; i < NS; i++) begin
      eX[i*10 +: 10] = mX[i]; eY[i*10 +: 10] = mY[i];
      eH[i*10 +: 10] = mH[i]; eL[i*10 +: 10] = mL[i];
      eAct[i] = mActive[i];
    end
    check("Gen_Load",       64'(Gen_Load),       64'(mPhase == 1));
    check("Spawn_Done",     64'(Spawn_Done),     64'(mPhase == 3));
    check("Slot_Active",    64'(Slot_Active),    64'(eAct));
    check("Spawn_Count",    64'(Spawn_Count),    64'(mCount));
    check("Barrier_X",      64'(Barrier_X),      64'(eX));
    check("Barrier_Y",      64'(Barrier_Y),      64'(eY));
    check("Barrier_Height", 64'(Barrier_Height), 64'(eH));
    check("Barrier_Length", 64'(Barrier_Length), 64'(eL));
  endtask

  task automatic applyStimulus(input bit tick, input bit en);
    Frame_Tick  = tick;
    Game_Enable = en;
    Gen_X       = 10'($urandom_range(0, 1023));
    Gen_Y       = 10'($urandom_range(0, 1023));
    Gen_Height  = 10'($urandom_range(0, 1023));
    Gen_Length  = 10'($urandom_range(0, 1023));
    modelStep(tick, en);
    @(posedge Clk);
    #1;
    checkOutput();
  endtask

  function automatic int activeCount();
    int n = 0;
    for (int i = 0; i < NS; i++) if (mActive[i]) n++;
    return n;
  endfunction

  initial begin
    bit found;
    Reset = 1'b1; Game_Enable = 1'b0; Frame_Tick = 1'b0;
    Gen_X = '0; Gen_Y = '0; Gen_Height = '0; Gen_Length = '0;
    modelReset();
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1);
    Reset = 1'b0;

    // Regular ticks fill every slot, then random ticks drive expiry and refill.
    for (int c = 0; c < 60; c++) applyStimulus(c % 2 == 0, 1'b1);
    for (int c = 0; c < 300; c++) applyStimulus(1'($urandom_range(0, 1)), 1'b1);

    // Abort a spawn while the generator outputs are settling.
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      if (mPhase == 2) found = 1'b1;
      else applyStimulus(1'($urandom_range(0, 1)), 1'b1);
    end
    if (!found) begin
      checks++; errors++;
      $error("FAIL reachWait observed=timeout expected=settling phase");
    end
    applyStimulus(1'($urandom_range(0, 1)), 1'b0);
    for (int c = 0; c < 100; c++) applyStimulus(1'($urandom_range(0, 1)), 1'b1);

    // Occasional enable drops at arbitrary points, then a tick on every cycle.
    for (int c = 0; c < 300; c++)
      applyStimulus(1'($urandom_range(0, 1)), $urandom_range(0, 29) != 0);
    for (int c = 0; c < 80; c++) applyStimulus(1'b1, 1'b1);

    // Asynchronous reset while strobing the generator with two or more live slots.
    found = 1'b0;
    for (int c = 0; c < 600 && !found; c++) begin
      if (mPhase == 1 && activeCount() >= 2) found = 1'b1;
      else applyStimulus(1'($urandom_range(0, 1)), 1'b1);
    end
    if (!found) begin
      checks++; errors++;
      $error("FAIL reachLoad observed=timeout expected=strobe with 2 live slots");
    end
    Reset = 1'b1;
    #1;
    modelReset();
    checkOutput();
    applyStimulus(1'b1, 1'b1);
    Reset = 1'b0;
    for (int c = 0; c < 60; c++) applyStimulus(1'($urandom_range(0, 1)), 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/barrier_spawn_scheduler.md
# barrier_spawn_scheduler

Sequences barrier creation for the playfield. It counts frames, decides when a new barrier spawns, and pulses the barrier parameter generator's load strobe. It captures the freshly latched X/Y/height/length into a free barrier slot, then ages each slot and retires it after a fixed lifetime. It sits between the frame timing logic and the barrier draw and collision logic, which read the slot outputs.

## Interface
Parameters:
- NUM_SLOTS, 4, number of concurrent barrier slots (1–8)
- SPAWN_INTERVAL, 60, frames between spawn attempts (1–255)
- LIFETIME, 300, frames a barrier stays active (1–511)

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high
- Frame_Tick  in  1  one-Clk-cycle pulse per video frame, synchronous to Clk
- Game_Enable  in  1  high while a game is running; low clears the playfield
- Gen_X, Gen_Y, Gen_Height, Gen_Length  in  10 each  latched outputs of the parameter generator
- Gen_Load  out  1  one-cycle strobe to the generator, which latches new parameters on it
- Barrier_X, Barrier_Y, Barrier_Height, Barrier_Length  out  NUM_SLOTS*10 each  slot i occupies bits [10i+9:10i]
- Slot_Active  out  NUM_SLOTS  bit i high while slot i holds a live barrier
- Spawn_Done  out  1  one-cycle pulse when a slot is written
- Spawn_Count  out  8  total barriers spawned since reset, wraps 255→0

## Operation
- FSM states: IDLE, LOAD, WAIT, CAPTURE.
- IDLE→LOAD requires all of: Game_Enable=1, spawn counter==0, at least one Slot_Active bit low.
  - On that transition the target slot is the lowest-index free slot; it is registered and held through CAPTURE.
  - The spawn counter reloads to SPAWN_INTERVAL on the same transition.
- LOAD: Gen_Load=1. Next state is WAIT.
- WAIT: Gen_Load=0. The generator outputs settle. Next state is CAPTURE.
- CAPTURE: writes Gen_X/Y/Height/Length into the target slot, sets its Slot_Active bit and loads its lifetime counter with LIFETIME. Spawn_Done=1 and Spawn_Count increments. Next state is IDLE.
- Spawn counter (8 bit):
  - Decrements on Frame_Tick when nonzero.
  - Holds at 0 until a spawn is launched. If all slots are full, the spawn fires on the first IDLE cycle after a slot frees.
- Lifetime counters (9 bit, one per slot):
  - Decrement on Frame_Tick while the slot is active.
  - A tick with the counter at 1 clears Slot_Active on the next edge and zeroes the counter.
- Slot parameter registers keep their last values after expiry. Consumers qualify them with Slot_Active.
- Game_Enable=0, checked every cycle, overrides everything:
  - Clears all Slot_Active bits and lifetime counters.
  - Forces the FSM to IDLE, including aborting a spawn in LOAD/WAIT/CAPTURE with no slot write and no Spawn_Done.
  - Reloads the spawn counter to SPAWN_INTERVAL.
  - Spawn_Count is not cleared.
- Simultaneous events:
  - Capture plus Frame_Tick on the target slot: the capture wins and the counter equals LIFETIME.
  - Frame_Tick during LOAD/WAIT/CAPTURE: decrements the spawn counter, which was reloaded on the transition out of IDLE.
  - A slot expiring while another is being captured: both take effect in the same cycle.

## Timing
- Reset values: FSM IDLE, Gen_Load=0, Spawn_Done=0, Spawn_Count=0, Slot_Active=0, all Barrier_* = 0, lifetime counters 0, spawn counter = SPAWN_INTERVAL.
- Spawn latency from the IDLE cycle that qualifies at edge T:
  - Gen_Load is high in cycle T+1.
  - Spawn_Done and the slot write happen in cycle T+3.
  - Slot_Active and the new Barrier_* values are visible from T+4.
- Every transaction occupies the FSM for exactly 4 cycles, IDLE included. Gen_Load never lasts more than 1 cycle.
- Expiry: Slot_Active falls on the edge following the Frame_Tick cycle in which the counter was 1.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Reset asserted mid-transaction returns every output to its reset value immediately.

## Test plan
- Reset, Game_Enable=1, 60 Frame_Ticks → Gen_Load pulse 1 cycle after counter reaches 0. With Gen_* = X=250, Y=80, H=20, L=40, slot 0 reads those values, Slot_Active=0001, Spawn_Count=1.
- SPAWN_INTERVAL=2, LIFETIME=300, 12 ticks → slots fill 0,1,2,3 in order. Slot_Active=1111; the counter holds at 0 and no further Gen_Load occurs.
- Continue ticking until slot 0's 300th post-capture tick → slot 0 clears, the next spawn refills slot 0 within 4 cycles, Slot_Active=1111 again.
- Assert Frame_Tick in the same cycle as CAPTURE → slot lifetime = LIFETIME. Expiry occurs exactly LIFETIME ticks later.
- Drop Game_Enable during WAIT → no Spawn_Done, Slot_Active=0000, FSM IDLE, Spawn_Count unchanged. After re-enable, the first spawn comes after SPAWN_INTERVAL ticks.
- Assert Reset during LOAD with 2 slots active → all outputs return to reset values immediately, and Gen_Load is low in the same cycle.
